// File: rtl/qed_pkg.sv
// Shared types and defaults for the QED replay path.
package qed_pkg;

  localparam int QED_INSN_W   = 32;
  localparam int QED_RB_DEPTH = 16;

  typedef enum logic [1:0] {
    CAPTURE = 2'd0,
    REPLAY  = 2'd1,
    DRAINED = 2'd2
  } qed_rb_state_t;

endpackage

// File: rtl/qed_replay_ram.sv
// Instruction storage for the replay buffer.
// One synchronous write port and one combinational read port; the array has no reset.
module qed_replay_ram #(
  parameter int INSN_W = 32,
  parameter int DEPTH  = 16,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [INSN_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [INSN_W-1:0] rdata
);

  logic [INSN_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/qed_replay_buffer.sv
// QED replay buffer: captures original-phase instructions into a FIFO and
// replays them in program order during the duplicate phase.
module qed_replay_buffer
  import qed_pkg::*;
#(
  parameter int INSN_W = QED_INSN_W,
  parameter int DEPTH  = QED_RB_DEPTH,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              exec_dup,
  input  logic              stall_IF,
  input  logic              ifu_vld,
  input  logic              flush,
  input  logic [INSN_W-1:0] ifu_qed_instruction,
  output logic [INSN_W-1:0] qic_qimux_instruction,
  output logic              vld_out,
  output logic [PTR_W:0]    count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              replay_done
);

  localparam logic [PTR_W:0] CNT_MAX = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] CNT_ONE = (PTR_W+1)'(1);

  qed_rb_state_t     state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [INSN_W-1:0] dout_q, dout_d;
  logic              vld_q, vld_d;
  logic              done_q, done_d;

  logic              full_w, empty_w;
  logic              cap_try, push, drop, pop;
  logic [INSN_W-1:0] rdata;

  assign full_w  = (count_q == CNT_MAX);
  assign empty_w = (count_q == '0);

  // Capture and replay qualifiers; flush wins over both.
  assign cap_try = (state_q == CAPTURE) & ena & ifu_vld & ~exec_dup & ~stall_IF & ~flush;
  assign push    = cap_try & ~full_w;
  assign drop    = cap_try & full_w;
  assign pop     = (state_q == REPLAY) & ena & exec_dup & ~stall_IF & ~empty_w & ~flush;

  qed_replay_ram #(
    .INSN_W (INSN_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (ifu_qed_instruction),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | drop;
    dout_d     = dout_q;
    vld_d      = vld_q;
    done_d     = done_q;

    if (flush) begin
      state_d  = CAPTURE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      vld_d    = 1'b0;
      done_d   = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        count_d  = count_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        count_d  = count_q - 1'b1;
        dout_d   = rdata;
      end

      // A stall freezes the output register, including valid and done.
      if (!ena) begin
        vld_d  = 1'b0;
        done_d = 1'b0;
      end else if (!stall_IF) begin
        vld_d  = pop;
        done_d = pop & (count_q == CNT_ONE);
      end

      if (ena) begin
        case (state_q)
          CAPTURE: if (exec_dup) state_d = REPLAY;
          REPLAY: begin
            if (!exec_dup)                          state_d = CAPTURE;
            else if (pop && (count_q == CNT_ONE))   state_d = DRAINED;
          end
          DRAINED: if (!exec_dup) state_d = CAPTURE;
          default: state_d = CAPTURE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= CAPTURE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      dout_q     <= '0;
      vld_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      dout_q     <= dout_d;
      vld_q      <= vld_d;
      done_q     <= done_d;
    end
  end

  assign qic_qimux_instruction = dout_q;
  assign vld_out               = vld_q;
  assign count                 = count_q;
  assign full                  = full_w;
  assign empty                 = empty_w;
  assign overflow              = overflow_q;
  assign replay_done           = done_q;

endmodule
